// File: rtl/prog_loader_pkg.sv
// prog_loader_pkg: shared widths and loader state encoding
package prog_loader_pkg;

    localparam int PL_CNTR_WIDTH = 8;
    localparam int PL_ADDR_WIDTH = 5;
    localparam int PL_UNDEFINED  = 3;
    localparam int PL_DATA_WIDTH = 16;
    localparam int CSUM_WIDTH    = 8;
    localparam int WORD_BYTES    = 3;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        COUNT = 3'd1,
        WORD  = 3'd2,
        CSUM  = 3'd3,
        DONE  = 3'd4,
        ERROR = 3'd5
    } state_t;

endpackage

// File: rtl/prog_loader_word_assembler.sv
// word_assembler: shifts accepted bytes MSB-first into one instruction word
module word_assembler
    import prog_loader_pkg::*;
#(
    parameter int WORD_WIDTH = 24
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  byte_valid,
    input  logic [CSUM_WIDTH-1:0] byte_data,
    output logic [WORD_WIDTH-1:0] word,
    output logic                  word_done
);

    logic [1:0]                       lane;
    logic [WORD_WIDTH-CSUM_WIDTH-1:0] sreg;

    // the final byte is spliced in combinationally so the word is ready on its accepting edge
    assign word_done = byte_valid && lane == 2'(WORD_BYTES - 1);
    assign word      = {sreg, byte_data};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lane <= '0;
            sreg <= '0;
        end else if (clear) begin
            lane <= '0;
            sreg <= '0;
        end else if (byte_valid) begin
            lane <= word_done ? '0 : lane + 2'd1;
            sreg <= {sreg[WORD_WIDTH-2*CSUM_WIDTH-1:0], byte_data};
        end
    end

endmodule

// File: rtl/prog_loader.sv
// prog_loader: loads a counted, checksummed byte stream into program memory
// and releases the core from reset only after a matching checksum.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int CNTR_WIDTH    = PL_CNTR_WIDTH,
    parameter int ADDR_WIDTH    = PL_ADDR_WIDTH,
    parameter int UNDEFINED     = PL_UNDEFINED,
    parameter int DATA_WIDTH    = PL_DATA_WIDTH,
    parameter int COMBINED_DATA = ADDR_WIDTH + UNDEFINED + DATA_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     in_valid,
    input  logic [CSUM_WIDTH-1:0]    in_data,
    output logic                     in_ready,
    output logic                     prog_we,
    output logic [CNTR_WIDTH-1:0]    prog_addr,
    output logic [COMBINED_DATA-1:0] prog_wdata,
    output logic                     core_rst_n,
    output logic                     busy,
    output logic                     err
);

    state_t                  state, next;
    logic                    accept, load_start, word_byte, word_done, last_word;
    logic [CNTR_WIDTH-1:0]   count, word_cnt;
    logic [CSUM_WIDTH-1:0]   csum;
    logic [COMBINED_DATA-1:0] word;

    assign accept     = in_valid && in_ready;
    assign load_start = start && (state == IDLE || state == DONE || state == ERROR);
    assign word_byte  = accept && state == WORD;
    // count of 0 means a full memory: count-1 wraps to the last index
    assign last_word  = word_cnt == count - CNTR_WIDTH'(1);

    word_assembler #(.WORD_WIDTH(COMBINED_DATA)) u_asm (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (load_start),
        .byte_valid(word_byte),
        .byte_data (in_data),
        .word      (word),
        .word_done (word_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next;
    end

    always_comb begin
        next       = state;
        in_ready   = state == COUNT || state == WORD || state == CSUM;
        busy       = in_ready;
        core_rst_n = state == DONE;
        case (state)
            IDLE, DONE, ERROR: next = start ? COUNT : state;
            COUNT:             next = accept ? WORD : state;
            WORD:              next = (word_done && last_word) ? CSUM : state;
            CSUM:              next = !accept ? state : (in_data == csum) ? DONE : ERROR;
            default:           next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count      <= '0;
            word_cnt   <= '0;
            csum       <= '0;
            prog_we    <= 1'b0;
            prog_addr  <= '0;
            prog_wdata <= '0;
            err        <= 1'b0;
        end else begin
            prog_we <= word_done;
            if (word_done) begin
                prog_addr  <= word_cnt;
                prog_wdata <= word;
                word_cnt   <= word_cnt + CNTR_WIDTH'(1);
            end
            if (accept && state == COUNT) count <= CNTR_WIDTH'(in_data);
            if (word_byte) csum <= csum ^ in_data;
            if (load_start) begin
                word_cnt <= '0;
                csum     <= '0;
                err      <= 1'b0;
            end
            if (state == CSUM && next == ERROR) err <= 1'b1;
        end
    end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter CNTR_WIDTH, 8, program address width; program depth is 2^CNTR_WIDTH words.
REQ-002 Parameter ADDR_WIDTH, 5, opcode field width.
REQ-003 Parameter UNDEFINED, 3, register-select field width.
REQ-004 Parameter DATA_WIDTH, 16, immediate field width.
REQ-005 Parameter COMBINED_DATA, ADDR_WIDTH+UNDEFINED+DATA_WIDTH (24), instruction word width.
REQ-006 Port clk, input, 1, single clock; all state changes on its rising edge.
REQ-007 Port rst_n, input, 1, asynchronous active-low reset.
REQ-008 Port start, input, 1, single-cycle pulse that begins a load.
REQ-009 Port in_valid, input, 1, byte-stream data valid.
REQ-010 Port in_data, input, 8, byte-stream payload.
REQ-011 Port in_ready, output, 1, loader accepts in_data when in_valid and in_ready are high on the same clk edge.
REQ-012 Port prog_we, output, 1, program memory write strobe.
REQ-013 Port prog_addr, output, CNTR_WIDTH, program memory write address.
REQ-014 Port prog_wdata, output, COMBINED_DATA, instruction word written.
REQ-015 Port core_rst_n, output, 1, drives the core rst_ext input; low holds the core in reset.
REQ-016 Port busy, output, 1, load in progress.
REQ-017 Port err, output, 1, last load failed its checksum.

Function
REQ-018 Stream format: one count byte N (0 encodes 2^CNTR_WIDTH words), then 3 bytes per word with the MSB byte first (bits 23:16, 15:8, 7:0), then one checksum byte equal to the XOR of every word byte.
REQ-019 FSM states: IDLE, COUNT, WORD, CSUM, DONE, ERROR; the encoding is a shared constant.
REQ-020 IDLE -> COUNT on start; COUNT -> WORD on accepting the count byte; WORD -> CSUM on accepting the third byte of word N-1; CSUM -> DONE on a match, or -> ERROR on a mismatch.
REQ-021 DONE or ERROR -> COUNT on start (reload); start in COUNT, WORD or CSUM is ignored.
REQ-022 in_ready is high only in COUNT, WORD and CSUM; bytes presented in other states are not consumed.
REQ-023 A byte lane counter (0..2) and a word counter (0..2^CNTR_WIDTH-1) advance only on accepted bytes; in_valid gaps stall without side effects.
REQ-024 prog_we pulses for exactly one cycle, in the cycle after the edge that accepted a word's third byte, with prog_addr equal to the word index (starting at 0) and prog_wdata equal to the assembled word.
REQ-025 prog_addr, prog_wdata and prog_we are registered; prog_we is low in every other cycle.
REQ-026 For N=0 the loader writes 2^CNTR_WIDTH words, and the word counter wraps to 0 only on the final word.
REQ-027 The running XOR clears on entry to COUNT; the count byte is excluded from it.
REQ-028 core_rst_n is low in every state except DONE; it goes high in the cycle after the matching checksum byte is accepted, and goes low at the edge that accepts a reload start.
REQ-029 busy is high in COUNT, WORD and CSUM.
REQ-030 err is set on entry to ERROR and cleared on start.

Reset
REQ-031 While rst_n is low, regardless of clk: state=IDLE, counters=0, XOR=0, prog_we=0, prog_addr=0, prog_wdata=0, in_ready=0, core_rst_n=0, busy=0, err=0.
REQ-032 Reset mid-load abandons the load, and no further prog_we pulse is issued for a partially assembled word.
REQ-033 Release of rst_n lands in IDLE; no load starts without a fresh start pulse.

Structure
REQ-034 The width parameters, the state encoding and the checksum byte width live in the shared parameter package used by core.
REQ-035 A single sub-module, word_assembler, shifts 3 bytes into one 24-bit word, counts the byte lanes, and raises a one-cycle word_done; the FSM, word counter, XOR and outputs stay in prog_loader.

Verification
REQ-036 start, then bytes 02, 0A,12,34, 81,00,05, checksum (0A^12^34^81^00^05)=A8 -> writes addr0=0A1234 and addr1=810005, then DONE, core_rst_n=1 one cycle after the checksum byte, err=0.
REQ-037 Same stream with checksum 00 -> ERROR, err=1, core_rst_n stays 0; a following start then a good stream -> DONE, err=0.
REQ-038 Good stream with random in_valid gaps (0-5 cycles) -> identical writes and order, exactly N prog_we pulses, and no byte consumed while in_ready=0.
REQ-039 Count byte 00 with 256 words of data equal to the index -> 256 writes at addr 0..255 with data = index, no address repeated, DONE on the correct checksum.
REQ-040 rst_n pulsed low after the 2nd byte of word 1 -> outputs reach reset values immediately, no write to addr1, IDLE after release.
REQ-041 start pulsed in WORD -> ignored; start in DONE -> core_rst_n falls at that edge and a reload proceeds normally.
